// File: rtl/commit_controller.sv
// In-order retirement sequencer: turns each ready ROB head entry into exactly one
// commit (register write, store release handshake, or write followed by a flush).
module commit_controller #(
    parameter int XLEN          = 32,
    parameter int REG_CNT_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rob_head_valid,
    input  logic                     rob_head_ready,
    input  logic                     rob_head_wb,
    input  logic [REG_CNT_WIDTH-1:0] rob_head_rd,
    input  logic [XLEN-1:0]          rob_head_val,
    input  logic                     rob_head_store,
    input  logic                     rob_head_mispredict,
    input  logic [XLEN-1:0]          rob_head_target,
    input  logic                     rob_head_halt,
    input  logic                     lsb_store_done,
    output logic                     rob_commit,
    output logic                     rf_wr_en,
    output logic [REG_CNT_WIDTH-1:0] rf_wr_rd,
    output logic [XLEN-1:0]          rf_wr_val,
    output logic                     lsb_store_go,
    output logic                     flush,
    output logic [XLEN-1:0]          flush_pc,
    output logic                     halted,
    output logic [31:0]              instret,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_STORE_WAIT = 2'd1,
        S_FLUSH      = 2'd2,
        S_HALT       = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     rob_commit_q, rob_commit_d;
    logic                     rf_wr_en_q, rf_wr_en_d;
    logic [REG_CNT_WIDTH-1:0] rf_wr_rd_q, rf_wr_rd_d;
    logic [XLEN-1:0]          rf_wr_val_q, rf_wr_val_d;
    logic                     lsb_store_go_q, lsb_store_go_d;
    logic                     flush_q, flush_d;
    logic [XLEN-1:0]          flush_pc_q, flush_pc_d;
    logic                     halted_q, halted_d;
    logic [31:0]              instret_q, instret_d;

    // The head is taken only when it is valid and ready and no commit is in flight:
    // the ROB pops on the edge that ends a rob_commit cycle, so during that cycle the
    // head still shows the entry just retired. The store handshake is a go pulse
    // followed by a level done that is only trusted once the go pulse has dropped.
    logic head_take;
    logic store_done_ok;

    assign head_take     = rob_head_valid && rob_head_ready && !rob_commit_q;
    assign store_done_ok = lsb_store_done && !lsb_store_go_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_RUN;
            rob_commit_q   <= 1'b0;
            rf_wr_en_q     <= 1'b0;
            rf_wr_rd_q     <= '0;
            rf_wr_val_q    <= '0;
            lsb_store_go_q <= 1'b0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
            halted_q       <= 1'b0;
            instret_q      <= '0;
        end else begin
            state_q        <= state_d;
            rob_commit_q   <= rob_commit_d;
            rf_wr_en_q     <= rf_wr_en_d;
            rf_wr_rd_q     <= rf_wr_rd_d;
            rf_wr_val_q    <= rf_wr_val_d;
            lsb_store_go_q <= lsb_store_go_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
            halted_q       <= halted_d;
            instret_q      <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                S_RUN: begin
                    if (head_take) begin
                        if (rob_head_halt) begin
                            state_d = S_HALT;
                        end else if (rob_head_store) begin
                            state_d = S_STORE_WAIT;
                        end else if (rob_head_mispredict) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
                S_STORE_WAIT: if (store_done_ok) state_d = S_RUN;
                S_FLUSH:      state_d = S_RUN;
                S_HALT:       state_d = S_HALT;
                default:      state_d = S_RUN;
            endcase
        end
    end

    // Pulses default low every cycle; latched data and counters hold unless updated.
    always_comb begin
        rob_commit_d   = 1'b0;
        rf_wr_en_d     = 1'b0;
        lsb_store_go_d = 1'b0;
        flush_d        = 1'b0;
        rf_wr_rd_d     = rf_wr_rd_q;
        rf_wr_val_d    = rf_wr_val_q;
        flush_pc_d     = flush_pc_q;
        halted_d       = halted_q;
        instret_d      = instret_q;
        if (rdy) begin
            case (state_q)
                S_RUN: begin
                    if (head_take) begin
                        if (rob_head_halt) begin
                            rob_commit_d = 1'b1;
                            halted_d     = 1'b1;
                        end else if (rob_head_store) begin
                            lsb_store_go_d = 1'b1;
                        end else begin
                            rob_commit_d = 1'b1;
                            rf_wr_en_d   = rob_head_wb && (rob_head_rd != '0);
                            rf_wr_rd_d   = rob_head_rd;
                            rf_wr_val_d  = rob_head_val;
                            instret_d    = instret_q + 32'd1;
                            if (rob_head_mispredict) begin
                                flush_pc_d = rob_head_target;
                            end
                        end
                    end
                end
                S_STORE_WAIT: begin
                    if (store_done_ok) begin
                        rob_commit_d = 1'b1;
                        instret_d    = instret_q + 32'd1;
                    end
                end
                S_FLUSH: flush_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign rob_commit   = rob_commit_q;
    assign rf_wr_en     = rf_wr_en_q;
    assign rf_wr_rd     = rf_wr_rd_q;
    assign rf_wr_val    = rf_wr_val_q;
    assign lsb_store_go = lsb_store_go_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;
    assign halted       = halted_q;
    assign instret      = instret_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_commit_controller.sv
// Bench for commit_controller: directed scenarios followed by a randomized ROB/LSB
// environment, every cycle compared against a rule-level reference model.
module tb_commit_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        rob_head_valid = 1'b0;
    logic        rob_head_ready = 1'b0;
    logic        rob_head_wb = 1'b0;
    logic [4:0]  rob_head_rd = '0;
    logic [31:0] rob_head_val = '0;
    logic        rob_head_store = 1'b0;
    logic        rob_head_mispredict = 1'b0;
    logic [31:0] rob_head_target = '0;
    logic        rob_head_halt = 1'b0;
    logic        lsb_store_done = 1'b0;
    logic        rob_commit;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_rd;
    logic [31:0] rf_wr_val;
    logic        lsb_store_go;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halted;
    logic [31:0] instret;
    logic [1:0]  dbg_state;

    commit_controller #(.XLEN(32), .REG_CNT_WIDTH(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .rob_head_valid      (rob_head_valid),
        .rob_head_ready      (rob_head_ready),
        .rob_head_wb         (rob_head_wb),
        .rob_head_rd         (rob_head_rd),
        .rob_head_val        (rob_head_val),
        .rob_head_store      (rob_head_store),
        .rob_head_mispredict (rob_head_mispredict),
        .rob_head_target     (rob_head_target),
        .rob_head_halt       (rob_head_halt),
        .lsb_store_done      (lsb_store_done),
        .rob_commit          (rob_commit),
        .rf_wr_en            (rf_wr_en),
        .rf_wr_rd            (rf_wr_rd),
        .rf_wr_val           (rf_wr_val),
        .lsb_store_go        (lsb_store_go),
        .flush               (flush),
        .flush_pc            (flush_pc),
        .halted              (halted),
        .instret             (instret),
        .dbg_state           (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural facts plus the pulses expected this cycle.
    logic        m_halted, m_store_wait, m_flush_due;
    logic [31:0] m_instret, m_flush_pc, m_val;
    logic [4:0]  m_rd;
    logic        e_commit, e_wr, e_go, e_flush;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        store;
        logic        mp;
        logic [31:0] target;
        logic        halt;
    } ent_t;
    ent_t rob_q[$];
    logic pop_next;
    logic lsb_pend;
    int   lsb_cnt;

    task automatic model_reset();
        m_halted = 0; m_store_wait = 0; m_flush_due = 0;
        m_instret = '0; m_flush_pc = '0; m_val = '0; m_rd = '0;
        e_commit = 0; e_wr = 0; e_go = 0; e_flush = 0;
        exp_q.delete();
        rob_q.delete();
        pop_next = 0; lsb_pend = 0; lsb_cnt = 0;
        lsb_store_done = 0;
    endtask

    // Applies the retirement rules to the inputs about to be sampled at the next edge.
    task automatic predict();
        logic n_commit, n_wr, n_go, n_flush;
        n_commit = 0; n_wr = 0; n_go = 0; n_flush = 0;
        if (rdy && !m_halted) begin
            if (m_flush_due) begin
                n_flush     = 1;
                m_flush_due = 0;
            end else if (m_store_wait) begin
                if (lsb_store_done && !e_go) begin
                    n_commit     = 1;
                    m_instret    = m_instret + 1;
                    m_store_wait = 0;
                end
            end else if (rob_head_valid && rob_head_ready && !e_commit) begin
                if (rob_head_halt) begin
                    n_commit = 1;
                    m_halted = 1;
                end else if (rob_head_store) begin
                    n_go         = 1;
                    m_store_wait = 1;
                end else begin
                    n_commit  = 1;
                    n_wr      = rob_head_wb && (rob_head_rd != 0);
                    m_rd      = rob_head_rd;
                    m_val     = rob_head_val;
                    m_instret = m_instret + 1;
                    if (n_wr) exp_q.push_back(rob_head_val);
                    if (rob_head_mispredict) begin
                        m_flush_pc  = rob_head_target;
                        m_flush_due = 1;
                    end
                end
            end
        end
        e_commit = n_commit; e_wr = n_wr; e_go = n_go; e_flush = n_flush;
    endtask

    task automatic check_all();
        logic [31:0] ev;
        chk("rob_commit", 32'(rob_commit), 32'(e_commit));
        chk("rf_wr_en", 32'(rf_wr_en), 32'(e_wr));
        chk("rf_wr_rd", 32'(rf_wr_rd), 32'(m_rd));
        chk("rf_wr_val", rf_wr_val, m_val);
        chk("lsb_store_go", 32'(lsb_store_go), 32'(e_go));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("flush_pc", flush_pc, m_flush_pc);
        chk("halted", 32'(halted), 32'(m_halted));
        chk("instret", instret, m_instret);
        chk("wr_flush_excl", 32'(rf_wr_en & flush), 32'd0);
        if (rf_wr_en) begin
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : ~rf_wr_val;
            chk("sb_wr_val", rf_wr_val, ev);
        end
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic set_head(input logic ready, input logic wb, input logic [4:0] rd,
                            input logic [31:0] val, input logic store, input logic mp,
                            input logic [31:0] target, input logic halt);
        rob_head_valid = 1; rob_head_ready = ready; rob_head_wb = wb; rob_head_rd = rd;
        rob_head_val = val; rob_head_store = store; rob_head_mispredict = mp;
        rob_head_target = target; rob_head_halt = halt;
    endtask

    task automatic idle_head();
        rob_head_valid = 0; rob_head_ready = 0; rob_head_wb = 0; rob_head_rd = '0;
        rob_head_val = '0; rob_head_store = 0; rob_head_mispredict = 0;
        rob_head_target = '0; rob_head_halt = 0;
    endtask

    // Called just after a falling edge: reset lands mid-cycle, well away from any edge.
    task automatic async_reset();
        #2 rst = 0;
        #1 model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1;
    endtask

    task automatic gen_entry(output ent_t e);
        int kind;
        kind     = $urandom_range(0, 99);
        e.halt   = (kind < 2);
        e.store  = (kind >= 2 && kind < 22);
        e.wb     = !e.store && ($urandom_range(0, 4) != 0);
        e.rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        e.val    = $urandom;
        e.mp     = ($urandom_range(0, 7) == 0);
        e.target = $urandom;
    endtask

    initial begin
        ent_t e;
        int   halt_cnt;
        model_reset();
        idle_head();
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        check_all();
        chk("reset_state", 32'(dbg_state), 32'd0);
        rst = 1;

        // ALU commit, then a different head presented while busy.
        set_head(1, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, '0, 0);
        step();
        chk("t1_commit", 32'(rob_commit), 32'd1);
        chk("t1_wr_en", 32'(rf_wr_en), 32'd1);
        chk("t1_rd", 32'(rf_wr_rd), 32'd5);
        chk("t1_val", rf_wr_val, 32'hDEAD_BEEF);
        chk("t1_instret", instret, 32'd1);
        set_head(1, 1, 5'd9, 32'h1, 0, 0, '0, 0);
        step();
        chk("t1_busy_commit", 32'(rob_commit), 32'd0);
        idle_head();
        step();

        // Write to x0 commits without a register write.
        set_head(1, 1, 5'd0, 32'd7, 0, 0, '0, 0);
        step();
        chk("t2_commit", 32'(rob_commit), 32'd1);
        chk("t2_wr_en", 32'(rf_wr_en), 32'd0);
        idle_head();
        step();

        // Mispredicted jalr: write first, flush the cycle after.
        set_head(1, 1, 5'd1, 32'h1004, 0, 1, 32'h2000, 0);
        step();
        chk("t3_wr_en", 32'(rf_wr_en), 32'd1);
        chk("t3_flush_early", 32'(flush), 32'd0);
        idle_head();
        step();
        chk("t3_flush", 32'(flush), 32'd1);
        chk("t3_flush_pc", flush_pc, 32'h2000);
        chk("t3_wr_en_off", 32'(rf_wr_en), 32'd0);
        step();

        // Store with done delayed and rdy dropped for one edge mid-wait.
        set_head(1, 0, 5'd0, 32'h0, 1, 1, 32'h4000, 0);
        step();
        chk("t4_go", 32'(lsb_store_go), 32'd1);
        chk("t4_no_commit", 32'(rob_commit), 32'd0);
        step();
        rdy = 0;
        step();
        rdy = 1;
        step();
        chk("t4_wait_commit", 32'(rob_commit), 32'd0);
        lsb_store_done = 1;
        step();
        chk("t4_commit", 32'(rob_commit), 32'd1);
        chk("t4_instret", instret, 32'd4);
        lsb_store_done = 0;
        idle_head();
        step();

        // Counter wrap from all-ones.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        chk("t5_preload", instret, 32'hFFFF_FFFF);
        set_head(1, 1, 5'd3, 32'h55, 0, 0, '0, 0);
        step();
        chk("t5_wrap", instret, 32'd0);
        idle_head();
        step();

        // Halt is absorbing until an asynchronous reset between edges.
        set_head(1, 0, 5'd0, 32'h0, 0, 1, 32'h8000, 1);
        step();
        chk("t6_commit", 32'(rob_commit), 32'd1);
        chk("t6_halted", 32'(halted), 32'd1);
        set_head(1, 1, 5'd7, 32'h77, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) step();
        chk("t6_no_pulse", 32'(rob_commit | rf_wr_en | lsb_store_go | flush), 32'd0);
        async_reset();
        chk("t6_arst_halted", 32'(halted), 32'd0);
        chk("t6_arst_instret", instret, 32'd0);
        idle_head();

        // Randomized ROB and LSB environment.
        halt_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (pop_next && rob_q.size() > 0) void'(rob_q.pop_front());
            pop_next = e_commit;
            if (e_commit && lsb_pend) begin
                lsb_pend       = 0;
                lsb_store_done = 0;
            end
            if (e_flush) begin
                rob_q.delete();
                pop_next = 0;
            end
            if (e_go) begin
                lsb_pend       = 1;
                lsb_cnt        = $urandom_range(0, 3);
                lsb_store_done = (lsb_cnt == 0);
            end else if (lsb_pend && !lsb_store_done) begin
                lsb_cnt--;
                lsb_store_done = (lsb_cnt <= 0);
            end
            if (rob_q.size() < 4 && $urandom_range(0, 1) == 1) begin
                gen_entry(e);
                rob_q.push_back(e);
            end
            if (rob_q.size() > 0 && !e_flush) begin
                set_head($urandom_range(0, 9) < 7, rob_q[0].wb, rob_q[0].rd, rob_q[0].val,
                         rob_q[0].store, rob_q[0].mp, rob_q[0].target, rob_q[0].halt);
            end else begin
                idle_head();
                rob_head_val = $urandom;
            end
            rdy = ($urandom_range(0, 9) != 0);
            step();
            if (m_halted) halt_cnt++;
            if (halt_cnt > 6) begin
                async_reset();
                halt_cnt = 0;
            end
        end

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
